// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the TX and RX sides.
//   - FSM state codes (Gray sequence IDLE->START->DATA->PARITY->STOP)
//   - parity type codes
//   - default data width and the bit-period helper
package uart_pkg;

    localparam int unsigned DataWidthDef = 8;

    localparam logic [2:0] StIdle   = 3'b000;
    localparam logic [2:0] StStart  = 3'b001;
    localparam logic [2:0] StData   = 3'b011;
    localparam logic [2:0] StParity = 3'b010;
    localparam logic [2:0] StStop   = 3'b110;

    localparam logic ParEven = 1'b0;
    localparam logic ParOdd  = 1'b1;

    // Last edge-counter value of a bit period; 6-bit wrap makes prescale 0 mean 64 clocks.
    function automatic logic [5:0] last_edge(input logic [5:0] prescale);
        return prescale - 6'd1;
    endfunction

endpackage

// File: rtl/uart_tx_fsm.sv
// UART transmit control FSM.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   data_valid_i   : send request (only honoured in IDLE)
//   bit_done_i     : current bit period ends this cycle
//   last_bit_i     : the data bit being sent is the final one
//   par_en_i       : latched parity enable
//   state_o        : current state
//   accept_o       : request accepted at this edge
//   ser_en_o, par_sel_o, stop_sel_o, busy_o : decode of the NEXT state, so the top can
//                    register tx_out and busy without an extra cycle of latency
module uart_tx_fsm
    import uart_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       data_valid_i,
    input  logic       bit_done_i,
    input  logic       last_bit_i,
    input  logic       par_en_i,
    output logic [2:0] state_o,
    output logic       accept_o,
    output logic       ser_en_o,
    output logic       par_sel_o,
    output logic       stop_sel_o,
    output logic       busy_o
);

    logic [2:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (data_valid_i) state_d = StStart;
            StStart:  if (bit_done_i) state_d = StData;
            StData:   if (bit_done_i && last_bit_i) state_d = par_en_i ? StParity : StStop;
            StParity: if (bit_done_i) state_d = StStop;
            StStop:   if (bit_done_i) state_d = StIdle;
            default:  state_d = StIdle;  // illegal codes recover to IDLE
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o    = state_q;
    assign accept_o   = (state_q == StIdle) && data_valid_i;
    assign ser_en_o   = (state_d == StData);
    assign par_sel_o  = (state_d == StParity);
    assign stop_sel_o = (state_d == StStop);
    assign busy_o     = (state_d != StIdle);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: serializes one byte per accepted request into an idle-high frame
// start(0), DATA_WIDTH data bits LSB-first, optional parity, stop(1); each bit lasts
// 'prescale' clocks (0 means 64).
//   clk, rst (async active-low)
//   p_data, data_valid, par_en, par_typ, prescale : request inputs, sampled at acceptance
//   tx_out : registered serial line, idle high
//   busy   : registered, high from acceptance until the stop bit ends
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DataWidthDef
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [5:0]            prescale,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] data_q, shift_q, shift_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [5:0]            edg_cnt_q, edg_cnt_d, prescale_q;
    logic                  par_en_q, par_typ_q;
    logic                  tx_q, tx_d, busy_q;

    logic [2:0] state;
    logic       accept, ser_en, par_sel, stop_sel, busy_d;
    logic       bit_done, parity;

    assign bit_done = (edg_cnt_q == last_edge(prescale_q));
    assign parity   = (^data_q) ^ par_typ_q;

    uart_tx_fsm u_fsm (
        .clk_i        (clk),
        .rst_ni       (rst),
        .data_valid_i (data_valid),
        .bit_done_i   (bit_done),
        .last_bit_i   (bit_cnt_q == LastBit),
        .par_en_i     (par_en_q),
        .state_o      (state),
        .accept_o     (accept),
        .ser_en_o     (ser_en),
        .par_sel_o    (par_sel),
        .stop_sel_o   (stop_sel),
        .busy_o       (busy_d)
    );

    always_comb begin
        edg_cnt_d = (state == StIdle || bit_done) ? 6'd0 : edg_cnt_q + 6'd1;

        shift_d = shift_q;
        if (accept) begin
            shift_d = p_data;
        end else if (state == StData && bit_done) begin
            shift_d = shift_q >> 1;
        end

        bit_cnt_d = bit_cnt_q;
        if (accept) begin
            bit_cnt_d = '0;
        end else if (state == StData && bit_done) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
        end

        // Line value for the state being entered, so tx_out changes on the same edge.
        if (ser_en) begin
            tx_d = shift_d[0];
        end else if (par_sel) begin
            tx_d = parity;
        end else if (stop_sel || !busy_d) begin
            tx_d = 1'b1;
        end else begin
            tx_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q     <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            edg_cnt_q  <= '0;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            if (accept) begin
                data_q     <= p_data;
                prescale_q <= prescale;
                par_en_q   <= par_en;
                par_typ_q  <= par_typ;
            end
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            edg_cnt_q <= edg_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level reference model (expected line value per
// clock, built from the frame format) is checked every cycle, plus a table of hand-computed
// frames and directed sequences for back-to-back, mid-frame reset and prescale corners.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] p_data = 8'h00;
    logic       data_valid = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [5:0] prescale = 6'd1;
    logic       tx_out;
    logic       busy;

    always #5 clk = ~clk;

    uart_tx #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .prescale   (prescale),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one expected line value per busy clock of the current frame.
    logic exp_q[$];
    bit   busy_m = 1'b0;

    typedef struct {
        logic [7:0]  data;
        logic        pe;
        logic        pt;
        logic [5:0]  pre;
        logic [10:0] bits;   // bit 0 = start bit, in transmission order
        int          nbits;
        int          len;
    } vec_t;

    vec_t vecs[6];

    function automatic int bit_len(input logic [5:0] p);
        return (p == 6'd0) ? 64 : int'(p);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic build_frame(input logic [7:0] d, input logic pe, input logic pt,
                               input logic [5:0] p);
        logic b[$];
        b.push_back(1'b0);
        for (int i = 0; i < 8; i++) b.push_back(d[i]);
        // Even parity: bit makes total ones even; odd parity inverts it.
        if (pe) b.push_back(logic'(($countones(d) % 2) == 1) ^ pt);
        b.push_back(1'b1);
        exp_q.delete();
        foreach (b[i]) begin
            for (int k = 0; k < bit_len(p); k++) exp_q.push_back(b[i]);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            exp_q.delete();
            busy_m = 1'b0;
        end else if (busy_m) begin
            void'(exp_q.pop_front());
            busy_m = (exp_q.size() > 0);
        end else if (data_valid) begin
            build_frame(p_data, par_en, par_typ, prescale);
            busy_m = 1'b1;
        end
        #1;
        check("tx_out", {31'd0, tx_out}, busy_m ? {31'd0, exp_q[0]} : 32'd1);
        check("busy", {31'd0, busy}, {31'd0, busy_m});
    endtask

    // Send one frame; optionally change prescale after switch_at ticks. Returns busy length.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic [5:0] p, input int switch_at,
                              input logic [5:0] alt_p, output int len);
        int n;
        p_data = d; par_en = pe; par_typ = pt; prescale = p; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        len = 0;
        n = 0;
        while (busy && n < 2000) begin
            len++;
            if (n == switch_at) prescale = alt_p;
            p_data = 8'($urandom);
            tick();
            n++;
        end
        check("frame_end", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, c, cnt, gap;
        logic prev_busy;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 6'd8,  {1'b0, 1'b1, 8'hA5, 1'b0}, 10, 80};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 6'd16, {1'b1, 1'b1, 8'h07, 1'b0}, 11, 176};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 6'd16, {1'b1, 1'b0, 8'h07, 1'b0}, 11, 176};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 6'd1,  {1'b0, 1'b1, 8'h3C, 1'b0}, 10, 10};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 6'd3,  {1'b1, 1'b1, 8'hFF, 1'b0}, 11, 33};
        vecs[5] = '{8'h00, 1'b1, 1'b0, 6'd0,  {1'b1, 1'b0, 8'h00, 1'b0}, 11, 704};

        // Reset held: random inputs must not disturb the idle line.
        #1 rst = 1'b0;
        #1;
        check("reset_tx", {31'd0, tx_out}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            p_data = 8'($urandom); data_valid = 1'($urandom); par_en = 1'($urandom);
            par_typ = 1'($urandom); prescale = 6'($urandom);
            tick();
        end
        data_valid = 1'b0;
        rst = 1'b1;
        repeat (3) tick();

        // Table of hand-computed frames, sampled mid-bit.
        for (int v = 0; v < 6; v++) begin
            p_data = vecs[v].data; par_en = vecs[v].pe; par_typ = vecs[v].pt;
            prescale = vecs[v].pre; data_valid = 1'b1;
            tick();
            data_valid = 1'b0;
            c = 0;
            cnt = 0;
            while (busy && c < 2000) begin
                cnt++;
                if ((c % bit_len(vecs[v].pre)) == bit_len(vecs[v].pre) / 2 &&
                    (c / bit_len(vecs[v].pre)) < vecs[v].nbits) begin
                    check($sformatf("vec%0d_bit%0d", v, c / bit_len(vecs[v].pre)),
                          {31'd0, tx_out}, {31'd0, vecs[v].bits[c / bit_len(vecs[v].pre)]});
                end
                // Mid-frame input changes must be ignored.
                p_data = 8'($urandom); par_en = 1'($urandom); par_typ = 1'($urandom);
                prescale = 6'($urandom);
                tick();
                c++;
            end
            check($sformatf("vec%0d_len", v), cnt, vecs[v].len);
        end

        // Back-to-back with data_valid held high and p_data toggling every clock.
        par_en = 1'b0; prescale = 6'd2; data_valid = 1'b1;
        prev_busy = busy;
        gap = 0;
        for (int i = 0; i < 70; i++) begin
            p_data = (i % 2 == 0) ? 8'h3C : 8'hC3;
            tick();
            if (!busy) gap++;
            if (busy && !prev_busy && i > 0) begin
                check("idle_gap", gap, 1);
            end
            if (busy) gap = 0;
            prev_busy = busy;
        end
        data_valid = 1'b0;
        while (busy_m) tick();
        tick();

        // Asynchronous reset in the middle of data bit 4.
        p_data = 8'h96; par_en = 1'b0; prescale = 6'd4; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        repeat (21) tick();
        #2 rst = 1'b0;
        #1;
        check("midreset_tx", {31'd0, tx_out}, 32'd1);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        send_frame(8'h96, 1'b1, 1'b0, 6'd4, -1, 6'd4, len);
        check("after_reset_len", len, 44);

        // prescale 0 means 64 clocks; a mid-frame change only affects the next frame.
        send_frame(8'h5B, 1'b1, 1'b1, 6'd0, 100, 6'd8, len);
        check("pre0_len", len, 704);
        send_frame(8'h5B, 1'b0, 1'b0, 6'd8, -1, 6'd8, len);
        check("pre8_len", len, 80);

        // Randomized traffic, including requests that arrive while busy.
        for (int i = 0; i < 400; i++) begin
            p_data = 8'($urandom); data_valid = ($urandom_range(0, 3) == 0);
            par_en = 1'($urandom); par_typ = 1'($urandom);
            prescale = 6'($urandom_range(1, 4));
            tick();
        end
        data_valid = 1'b0;
        for (int i = 0; i < 200 && busy_m; i++) tick();
        check("random_end_busy", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
